rle_symbol_encoder: RTL and testbench

- Consumes one zigzag-ordered 8x8 block as a parallel 512-bit vector from the zigzag buffer stage.
- Coefficient k sits at bits [8k+7:8k]; coefficient 0 is DC, 1..63 are AC.
- Serialises the block into JPEG entropy symbols (run, size, amplitude bits) over a valid/ready stream for the downstream Huffman coder.
- Computes the DC difference against a held predictor.

---
 rtl/jpeg_enc_pkg.sv | 20 ++
 rtl/rle_symbol_encoder_if.sv | 24 ++
 rtl/jpeg_size_amp.sv | 24 ++
 rtl/rle_symbol_encoder.sv | 161 ++++++++++++++++
 tb/tb_rle_symbol_encoder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/jpeg_enc_pkg.sv
// Shared JPEG encoder definitions: coefficient geometry, symbol field widths
// (also used by the Huffman stage) and the run-length encoder state encoding.
package jpeg_enc_pkg;
    localparam int COEF_W  = 8;
    localparam int NCOEF   = 64;
    localparam int BLOCK_W = NCOEF * COEF_W;
    localparam int IDX_W   = $clog2(NCOEF);
    localparam int RUN_W   = 4;
    localparam int SIZE_W  = 4;
    localparam int AMP_W   = COEF_W;

    localparam logic [RUN_W-1:0] ZRL_RUN = 4'd15;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DC   = 2'd1,
        AC   = 2'd2,
        EOB  = 2'd3
    } state_t;
endpackage

// File: rtl/rle_symbol_encoder_if.sv
// Symbol stream from the run-length encoder to the Huffman coder.
// Handshake: a symbol transfers on a posedge where sym_valid && sym_ready; once
// sym_valid is high it stays high with all sym_* fields frozen until that transfer.
interface rle_symbol_encoder_if;
    import jpeg_enc_pkg::*;

    logic              sym_valid;
    logic              sym_ready;
    logic [RUN_W-1:0]  sym_run;
    logic [SIZE_W-1:0] sym_size;
    logic [AMP_W-1:0]  sym_amp;
    logic              sym_is_dc;
    logic              sym_last;

    modport master (
        output sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last,
        input  sym_ready
    );

    modport slave (
        input  sym_valid, sym_run, sym_size, sym_amp, sym_is_dc, sym_last,
        output sym_ready
    );
endinterface

// File: rtl/jpeg_size_amp.sv
// JPEG magnitude category and amplitude bits of a signed value; negative values
// encode as (v-1) truncated to size bits, so bits above size are always zero.
module jpeg_size_amp
    import jpeg_enc_pkg::*;
(
    input  logic signed [COEF_W:0] i_value,
    output logic [SIZE_W-1:0]      o_size,
    output logic [AMP_W-1:0]       o_amp
);
    logic [COEF_W:0]   w_mag;
    logic [COEF_W-1:0] w_sel;
    logic [COEF_W-1:0] w_mask;

    always_comb begin
        w_mag = i_value[COEF_W] ? ({(COEF_W+1){1'b0}} - i_value) : i_value;
        o_size = '0;
        for (int b = 0; b <= COEF_W; b++) begin
            if (w_mag[b]) o_size = SIZE_W'(b + 1);
        end
        w_mask = ~({COEF_W{1'b1}} << o_size);
        w_sel  = i_value[COEF_W] ? (i_value[COEF_W-1:0] - 1'b1) : i_value[COEF_W-1:0];
        o_amp  = w_sel & w_mask;
    end
endmodule

// File: rtl/rle_symbol_encoder.sv
// Serialises one zigzag-ordered 8x8 block into JPEG (run, size, amplitude)
// symbols: DC difference first, then AC runs with ZRL, ending in EOB or coef 63.
module rle_symbol_encoder
    import jpeg_enc_pkg::*;
(
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [BLOCK_W-1:0] block_in,
    input  logic               dc_clear,
    output logic               busy,
    output state_t             dbg_state,
    rle_symbol_encoder_if.master sym
);
    state_t                   r_state;
    logic [BLOCK_W-1:0]       r_block;
    logic [COEF_W-1:0]        r_pred;
    logic [IDX_W-1:0]         r_idx;
    logic [IDX_W-1:0]         r_last_nz;
    logic [RUN_W-1:0]         r_run_cnt;
    logic                     r_busy;
    logic                     r_valid;
    logic [RUN_W-1:0]         r_run;
    logic [SIZE_W-1:0]        r_size;
    logic [AMP_W-1:0]         r_amp;
    logic                     r_is_dc;
    logic                     r_last;

    logic [IDX_W-1:0]         w_last_nz;
    logic [COEF_W-1:0]        w_coef;
    logic [COEF_W-1:0]        w_pred_eff;
    logic [COEF_W:0]          w_dc_diff;
    logic [COEF_W:0]          w_sa_in;
    logic [SIZE_W-1:0]        w_size;
    logic [AMP_W-1:0]         w_amp;
    logic                     w_hs;

    // Highest nonzero AC index of the incoming block; 0 means no AC content.
    always_comb begin
        w_last_nz = '0;
        for (int k = 1; k < NCOEF; k++) begin
            if (block_in[k*COEF_W +: COEF_W] != '0) w_last_nz = IDX_W'(k);
        end
    end

    assign w_coef     = r_block[32'(r_idx)*COEF_W +: COEF_W];
    assign w_pred_eff = dc_clear ? '0 : r_pred;
    assign w_dc_diff  = {block_in[COEF_W-1], block_in[COEF_W-1:0]} - {w_pred_eff[COEF_W-1], w_pred_eff};
    // The single size/amp unit serves the DC diff at start and AC coefs afterwards.
    assign w_sa_in    = (r_state == IDLE) ? w_dc_diff : {w_coef[COEF_W-1], w_coef};
    assign w_hs       = r_valid && sym.sym_ready;

    jpeg_size_amp u_size_amp (
        .i_value (w_sa_in),
        .o_size  (w_size),
        .o_amp   (w_amp)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_block   <= '0;
            r_pred    <= '0;
            r_idx     <= '0;
            r_last_nz <= '0;
            r_run_cnt <= '0;
            r_busy    <= 1'b0;
            r_valid   <= 1'b0;
            r_run     <= '0;
            r_size    <= '0;
            r_amp     <= '0;
            r_is_dc   <= 1'b0;
            r_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dc_clear) r_pred <= '0;
                    if (start) begin
                        r_block   <= block_in;
                        r_last_nz <= w_last_nz;
                        r_busy    <= 1'b1;
                        r_valid   <= 1'b1;
                        r_run     <= '0;
                        r_size    <= w_size;
                        r_amp     <= w_amp;
                        r_is_dc   <= 1'b1;
                        r_last    <= 1'b0;
                        r_state   <= DC;
                    end
                end
                DC: begin
                    if (w_hs) begin
                        r_valid   <= 1'b0;
                        r_is_dc   <= 1'b0;
                        r_pred    <= r_block[COEF_W-1:0];
                        r_idx     <= IDX_W'(1);
                        r_run_cnt <= '0;
                        r_state   <= AC;
                    end
                end
                AC: begin
                    if (r_valid) begin
                        if (sym.sym_ready) begin
                            r_valid   <= 1'b0;
                            r_run_cnt <= '0;
                            if (r_last) begin
                                r_last  <= 1'b0;
                                r_busy  <= 1'b0;
                                r_state <= IDLE;
                            end else begin
                                r_idx <= r_idx + 1'b1;
                            end
                        end
                    end else if (r_idx > r_last_nz) begin
                        r_valid <= 1'b1;
                        r_run   <= '0;
                        r_size  <= '0;
                        r_amp   <= '0;
                        r_last  <= 1'b1;
                        r_state <= EOB;
                    end else if (w_coef == '0) begin
                        if (r_run_cnt == ZRL_RUN) begin
                            r_valid <= 1'b1;
                            r_run   <= ZRL_RUN;
                            r_size  <= '0;
                            r_amp   <= '0;
                            r_last  <= 1'b0;
                        end else begin
                            r_run_cnt <= r_run_cnt + 1'b1;
                            r_idx     <= r_idx + 1'b1;
                        end
                    end else begin
                        r_valid <= 1'b1;
                        r_run   <= r_run_cnt;
                        r_size  <= w_size;
                        r_amp   <= w_amp;
                        r_last  <= (r_idx == IDX_W'(NCOEF - 1));
                    end
                end
                EOB: begin
                    if (w_hs) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy          = r_busy;
    assign dbg_state     = r_state;
    assign sym.sym_valid = r_valid;
    assign sym.sym_run   = r_run;
    assign sym.sym_size  = r_size;
    assign sym.sym_amp   = r_amp;
    assign sym.sym_is_dc = r_is_dc;
    assign sym.sym_last  = r_last;
endmodule

// File: tb/tb_rle_symbol_encoder.sv
// Directed bench for rle_symbol_encoder: table of blocks with hand-computed
// symbol lists, plus backpressure, busy-time ignore and mid-block reset sequences.
module tb_rle_symbol_encoder;
    import jpeg_enc_pkg::*;

    localparam int SYM_W = 18;
    typedef logic [0:5][SYM_W-1:0] sym6_t;
    typedef struct {
        logic [BLOCK_W-1:0] blk;
        logic               clr;
        int                 n;
        sym6_t              e;
    } vec_t;

    logic               clock;
    logic               reset_n;
    logic               start;
    logic [BLOCK_W-1:0] block_in;
    logic               dc_clear;
    logic               busy;
    state_t             dbg_state;

    rle_symbol_encoder_if sym_if();

    rle_symbol_encoder dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .block_in  (block_in),
        .dc_clear  (dc_clear),
        .busy      (busy),
        .dbg_state (dbg_state),
        .sym       (sym_if)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    logic [SYM_W-1:0] exp_q[$];
    localparam logic [BLOCK_W-1:0] Z = '0;

    function automatic logic [SYM_W-1:0] mk(input int run, input int size, input int amp,
                                            input bit is_dc, input bit last);
        return {4'(run), 4'(size), 8'(amp), is_dc, last};
    endfunction

    function automatic logic [BLOCK_W-1:0] put(input logic [BLOCK_W-1:0] b, input int k,
                                               input logic [7:0] v);
        logic [BLOCK_W-1:0] r;
        r = b;
        r[k*8 +: 8] = v;
        return r;
    endfunction

    function automatic vec_t make_vec(input logic [BLOCK_W-1:0] blk, input logic clr,
                                      input int n, input sym6_t e);
        vec_t v;
        v.blk = blk;
        v.clr = clr;
        v.n   = n;
        v.e   = e;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every handshake is compared against the head of exp_q.
    always @(negedge clock) begin
        if (reset_n && sym_if.sym_valid && sym_if.sym_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_symbol: got run=%0d size=%0d amp=0x%0h dc=%0b last=%0b with none expected",
                         sym_if.sym_run, sym_if.sym_size, sym_if.sym_amp, sym_if.sym_is_dc, sym_if.sym_last);
            end else begin
                check("symbol", {sym_if.sym_run, sym_if.sym_size, sym_if.sym_amp,
                                 sym_if.sym_is_dc, sym_if.sym_last}, exp_q.pop_front());
            end
        end
    end

    // Driver tasks
    task automatic start_block(input string name, input logic [BLOCK_W-1:0] blk, input logic clr);
        @(posedge clock); #1;
        block_in = blk;
        dc_clear = clr;
        start    = 1'b1;
        @(posedge clock); #1;
        start    = 1'b0;
        dc_clear = 1'b0;
        check({name, " busy_after_start"}, 32'(busy), 32'd1);
        check({name, " dc_valid_1cycle"}, 32'(sym_if.sym_valid), 32'd1);
    endtask

    task automatic wait_done(input string name);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clock); #1;
            cyc++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s timeout: got %0d symbols still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
        check({name, " busy_end"}, 32'(busy), 32'd0);
        check({name, " valid_end"}, 32'(sym_if.sym_valid), 32'd0);
        check({name, " state_end"}, 32'(dbg_state), 32'(IDLE));
    endtask

    task automatic run_block(input string name, input vec_t v);
        for (int i = 0; i < v.n; i++) exp_q.push_back(v.e[i]);
        start_block(name, v.blk, v.clr);
        wait_done(name);
    endtask

    vec_t vecs[7];

    initial begin
        logic [SYM_W-1:0] eob;
        logic [SYM_W-1:0] zrl;
        logic [BLOCK_W-1:0] b;
        int cyc;

        eob = mk(0, 0, 0, 0, 1);
        zrl = mk(15, 0, 0, 0, 0);
        vecs[0] = make_vec(Z, 1'b1, 2, {mk(0, 0, 0, 1, 0), eob, {4{18'd0}}});
        vecs[1] = make_vec(put(put(Z, 0, 8'd5), 1, 8'hFD), 1'b0, 3,
                           {mk(0, 3, 8'h05, 1, 0), mk(0, 2, 8'h00, 0, 0), eob, {3{18'd0}}});
        vecs[2] = make_vec(put(Z, 0, 8'd2), 1'b0, 2, {mk(0, 2, 8'h00, 1, 0), eob, {4{18'd0}}});
        vecs[3] = make_vec(put(Z, 20, 8'd1), 1'b1, 4,
                           {mk(0, 0, 0, 1, 0), zrl, mk(3, 1, 8'h01, 0, 0), eob, {2{18'd0}}});
        vecs[4] = make_vec(put(Z, 63, 8'h80), 1'b0, 5,
                           {mk(0, 0, 0, 1, 0), zrl, zrl, zrl, mk(14, 8, 8'h7F, 0, 1), 18'd0});
        vecs[5] = make_vec(put(put(put(Z, 0, 8'h80), 2, 8'h7F), 3, 8'hFF), 1'b0, 4,
                           {mk(0, 8, 8'h7F, 1, 0), mk(1, 7, 8'h7F, 0, 0), mk(0, 1, 8'h00, 0, 0), eob, {2{18'd0}}});
        vecs[6] = make_vec(put(put(put(Z, 0, 8'h7F), 1, 8'h40), 5, 8'hC0), 1'b0, 4,
                           {mk(0, 8, 8'hFF, 1, 0), mk(0, 7, 8'h40, 0, 0), mk(3, 7, 8'h3F, 0, 0), eob, {2{18'd0}}});

        reset_n  = 1'b0;
        start    = 1'b0;
        dc_clear = 1'b0;
        block_in = '0;
        sym_if.sym_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("rst valid", 32'(sym_if.sym_valid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst fields", {sym_if.sym_run, sym_if.sym_size, sym_if.sym_amp,
                             sym_if.sym_is_dc, sym_if.sym_last}, 32'd0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) run_block($sformatf("vec%0d", i), vecs[i]);

        // Backpressure on the AC symbol; start/dc_clear pulsed while busy.
        sym_if.sym_ready = 1'b0;
        exp_q.push_back(mk(0, 4, 8'h0A, 1, 0));
        exp_q.push_back(mk(0, 3, 8'h07, 0, 0));
        exp_q.push_back(eob);
        start_block("bp", put(put(Z, 0, 8'd10), 1, 8'd7), 1'b1);
        sym_if.sym_ready = 1'b1;
        @(posedge clock); #1;
        sym_if.sym_ready = 1'b0;
        cyc = 0;
        while (!sym_if.sym_valid && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        for (int i = 0; i < 5; i++) begin
            check("bp hold", {sym_if.sym_valid, sym_if.sym_run, sym_if.sym_size, sym_if.sym_amp,
                              sym_if.sym_is_dc, sym_if.sym_last}, {1'b1, mk(0, 3, 8'h07, 0, 0)});
            if (i == 1) begin
                block_in = put(Z, 0, 8'h55);
                start    = 1'b1;
                dc_clear = 1'b1;
            end else begin
                start    = 1'b0;
                dc_clear = 1'b0;
            end
            @(posedge clock); #1;
        end
        start    = 1'b0;
        dc_clear = 1'b0;
        sym_if.sym_ready = 1'b1;
        wait_done("bp");
        // Predictor must be 10 from the bp block, untouched by the busy-time dc_clear.
        run_block("bp_pred", make_vec(put(Z, 0, 8'd10), 1'b0, 2, {mk(0, 0, 0, 1, 0), eob, {4{18'd0}}}));

        // Reset in the middle of the AC scan.
        exp_q.push_back(mk(0, 6, 8'h28, 1, 0));
        start_block("mid_rst", put(put(Z, 0, 8'd50), 40, 8'd3), 1'b0);
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 20) begin
            @(posedge clock); #1;
            cyc++;
        end
        check("mid_rst dc_seen", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (8) @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        check("mid_rst valid", 32'(sym_if.sym_valid), 32'd0);
        check("mid_rst busy", 32'(busy), 32'd0);
        check("mid_rst state", 32'(dbg_state), 32'(IDLE));
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("post_rst quiet", 32'(sym_if.sym_valid), 32'd0);
        run_block("post_rst", make_vec(put(Z, 0, 8'd4), 1'b0, 2, {mk(0, 3, 8'h04, 1, 0), eob, {4{18'd0}}}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
